// File: rtl/as2650_bus_ctrl.sv
// Bus controller for the AS2650 CPU: runs memory cycles with programmable wait
// states, write-protects a low address window, and services two 8-bit I/O ports.
module as2650_bus_ctrl #(
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [12:0] PROTECT_TOP = 13'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [12:0] adr,
   input  logic        rw,
   input  logic        opreq,
   input  logic        m_io,
   input  logic        d_c,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        opack,
   output logic [12:0] mem_adr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        mem_ce_n,
   output logic        mem_oe_n,
   output logic        mem_we_n,
   output logic [7:0]  port_ctl_out,
   output logic [7:0]  port_dat_out,
   input  logic [7:0]  port_ctl_in,
   input  logic [7:0]  port_dat_in,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   // Handshake: a request is sampled only in IDLE on a rising edge with opreq=1;
   // opack stays high in ACK until the first edge that sees opreq=0.
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [12:0] adr_q, adr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        rw_q, rw_d;
   logic        wen_q, wen_d;
   logic [7:0]  din_q, din_d;
   logic [7:0]  pctl_q, pctl_d;
   logic [7:0]  pdat_q, pdat_d;
   logic [13:0] prot_diff;
   logic        in_protect;

   // Borrow out of adr - PROTECT_TOP marks adr < PROTECT_TOP.
   assign prot_diff  = {1'b0, adr} - {1'b0, PROTECT_TOP};
   assign in_protect = prot_diff[13];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         adr_q   <= 13'd0;
         wdata_q <= 8'd0;
         rw_q    <= 1'b0;
         wen_q   <= 1'b0;
         din_q   <= 8'd0;
         pctl_q  <= 8'd0;
         pdat_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         rw_q    <= rw_d;
         wen_q   <= wen_d;
         din_q   <= din_d;
         pctl_q  <= pctl_d;
         pdat_q  <= pdat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      rw_d    = rw_q;
      wen_d   = wen_q;
      din_d   = din_q;
      pctl_d  = pctl_q;
      pdat_d  = pdat_q;
      case (state_q)
         IDLE: begin
            if (opreq) begin
               adr_d   = adr;
               wdata_d = cpu_dout;
               rw_d    = rw;
               wen_d   = rw && !in_protect;
               if (m_io) begin
                  state_d = ACCESS;
                  cnt_d   = WS;
               end else begin
                  state_d = ACK;
                  if (rw) begin
                     if (d_c) pdat_d = cpu_dout;
                     else     pctl_d = cpu_dout;
                  end else begin
                     din_d = d_c ? port_dat_in : port_ctl_in;
                  end
               end
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ACK;
               if (!rw_q) din_d = mem_rdata;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK: begin
            if (!opreq) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes decode straight from state so an asynchronous reset drops them at once.
   assign mem_ce_n     = (state_q != ACCESS);
   assign mem_oe_n     = (state_q != ACCESS) || rw_q;
   assign mem_we_n     = (state_q != ACCESS) || !wen_q;
   assign opack        = (state_q == ACK);
   assign mem_adr      = adr_q;
   assign mem_wdata    = wdata_q;
   assign cpu_din      = din_q;
   assign port_ctl_out = pctl_q;
   assign port_dat_out = pdat_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_as2650_bus_ctrl.sv
// Bench for as2650_bus_ctrl: two instances (2 wait states with a protected window,
// and 0 wait states) share stimulus; directed table, corner sequences, random traffic.
module tb_as2650_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [12:0] adr;
   logic        rw, opreq, m_io, d_c;
   logic [7:0]  cpu_dout, mem_rdata, port_ctl_in, port_dat_in;

   logic [7:0]  cpu_din2, mem_wdata2, pctl2, pdat2;
   logic [12:0] mem_adr2;
   logic        opack2, ce2, oe2, we2;
   logic [1:0]  dbg2;
   logic [7:0]  cpu_din0, mem_wdata0, pctl0, pdat0;
   logic [12:0] mem_adr0;
   logic        opack0, ce0, oe0, we0;
   logic [1:0]  dbg0;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_din, exp_pctl, exp_pdat;

   always #5 clk = ~clk;

   as2650_bus_ctrl #(.WAIT_STATES(2), .PROTECT_TOP(13'h0800)) u_dut2 (
      .clk(clk), .reset(reset), .adr(adr), .rw(rw), .opreq(opreq), .m_io(m_io),
      .d_c(d_c), .cpu_dout(cpu_dout), .cpu_din(cpu_din2), .opack(opack2),
      .mem_adr(mem_adr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata),
      .mem_ce_n(ce2), .mem_oe_n(oe2), .mem_we_n(we2),
      .port_ctl_out(pctl2), .port_dat_out(pdat2),
      .port_ctl_in(port_ctl_in), .port_dat_in(port_dat_in), .dbg_state(dbg2)
   );

   as2650_bus_ctrl #(.WAIT_STATES(0)) u_dut0 (
      .clk(clk), .reset(reset), .adr(adr), .rw(rw), .opreq(opreq), .m_io(m_io),
      .d_c(d_c), .cpu_dout(cpu_dout), .cpu_din(cpu_din0), .opack(opack0),
      .mem_adr(mem_adr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata),
      .mem_ce_n(ce0), .mem_oe_n(oe0), .mem_we_n(we0),
      .port_ctl_out(pctl0), .port_dat_out(pdat0),
      .port_ctl_in(port_ctl_in), .port_dat_in(port_dat_in), .dbg_state(dbg0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, " din2"}, 32'(cpu_din2), 32'(exp_din));
      chk({tag, " din0"}, 32'(cpu_din0), 32'(exp_din));
      chk({tag, " pctl"}, {16'(pctl2), 16'(pctl0)}, {16'(exp_pctl), 16'(exp_pctl)});
      chk({tag, " pdat"}, {16'(pdat2), 16'(pdat0)}, {16'(exp_pdat), 16'(exp_pdat)});
   endtask

   // One CPU transaction; latency, strobe widths and data are checked against the
   // rules: memory ACCESS lasts WS+1 cycles, opack first seen 2+WS edges after the
   // request (1 edge for I/O), writes below PROTECT_TOP never pulse we_n.
   task automatic run_txn(input logic mio, input logic wr, input logic dc,
                          input logic [12:0] a, input logic [7:0] wd, input logic [7:0] rd,
                          input logic [7:0] ci, input logic [7:0] di,
                          input int hold, input bit pulse, output int we2c);
      int lat2, lat0, ce2c, ce0c, oe2c, oe0c, we0c, ack2c, ack0c, bad_adr;
      bit prot2;
      lat2 = 0; lat0 = 0; ce2c = 0; ce0c = 0; oe2c = 0; oe0c = 0; we2c = 0; we0c = 0;
      ack2c = 0; ack0c = 0; bad_adr = 0;
      prot2 = (a < 13'h0800);
      @(negedge clk);
      m_io = mio; rw = wr; d_c = dc; adr = a; cpu_dout = wd; mem_rdata = rd;
      port_ctl_in = ci; port_dat_in = di; opreq = 1'b1;
      for (int k = 1; k <= (pulse ? 8 : 40); k++) begin
         @(negedge clk);
         if (pulse) opreq = 1'b0;
         if (!ce2) begin
            ce2c++;
            if (mem_adr2 !== a || mem_wdata2 !== wd) bad_adr++;
         end
         if (!ce0) begin
            ce0c++;
            if (mem_adr0 !== a || mem_wdata0 !== wd) bad_adr++;
         end
         if (!oe2) oe2c++;
         if (!oe0) oe0c++;
         if (!we2) we2c++;
         if (!we0) we0c++;
         if (opack2) ack2c++;
         if (opack0) ack0c++;
         if (opack2 && lat2 == 0) lat2 = k;
         if (opack0 && lat0 == 0) lat0 = k;
         if (!pulse && lat2 != 0 && lat0 != 0) break;
      end
      chk("lat_ws2", lat2, mio ? 4 : 1);
      chk("lat_ws0", lat0, mio ? 2 : 1);
      chk("ce_cycles", {16'(ce2c), 16'(ce0c)}, mio ? {16'd3, 16'd1} : 32'd0);
      chk("oe_cycles", {16'(oe2c), 16'(oe0c)}, (mio && !wr) ? {16'd3, 16'd1} : 32'd0);
      chk("we_cycles_ws2", we2c, (mio && wr && !prot2) ? 3 : 0);
      chk("we_cycles_ws0", we0c, (mio && wr) ? 1 : 0);
      chk("access_adr_data", bad_adr, 0);
      if (mio && !wr) exp_din = rd;
      else if (!mio && wr && dc) exp_pdat = wd;
      else if (!mio && wr) exp_pctl = wd;
      else if (!mio) exp_din = dc ? di : ci;
      chk_state("txn");
      if (pulse) begin
         chk("pulse_ack_count", {16'(ack2c), 16'(ack0c)}, {16'd1, 16'd1});
      end else begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            adr = 13'($urandom);
            chk("hold_ack", {opack2, opack0, ce2, ce0}, 4'b1111);
         end
         opreq = 1'b0;
         @(negedge clk);
         chk("ack_release", {opack2, opack0}, 2'b00);
      end
   endtask

   typedef struct {
      logic mio, wr, dc;
      logic [12:0] a;
      logic [7:0] wd, rd, ci, di;
      int hold;
      bit pulse;
      logic [7:0] exp_din;
      int exp_we2;
   } vec_t;

   vec_t vecs[9];
   int wc;

   initial begin
      vecs[0] = '{1, 0, 0, 13'h0123, 8'h00, 8'hA5, 8'h00, 8'h00, 0, 0, 8'hA5, 0};
      vecs[1] = '{1, 1, 0, 13'h1000, 8'h3C, 8'h11, 8'h00, 8'h00, 0, 0, 8'hA5, 3};
      vecs[2] = '{1, 1, 0, 13'h07FF, 8'h77, 8'h22, 8'h00, 8'h00, 0, 0, 8'hA5, 0};
      vecs[3] = '{1, 1, 0, 13'h0800, 8'h66, 8'h33, 8'h00, 8'h00, 0, 0, 8'hA5, 3};
      vecs[4] = '{0, 1, 1, 13'h0001, 8'h5A, 8'h44, 8'h00, 8'h00, 0, 0, 8'hA5, 0};
      vecs[5] = '{0, 0, 0, 13'h0002, 8'h00, 8'h55, 8'h81, 8'h18, 0, 0, 8'h81, 0};
      vecs[6] = '{1, 0, 0, 13'h1FFF, 8'h00, 8'h42, 8'h00, 8'h00, 5, 0, 8'h42, 0};
      vecs[7] = '{1, 0, 0, 13'h0456, 8'h00, 8'h99, 8'h00, 8'h00, 0, 1, 8'h99, 0};
      vecs[8] = '{0, 1, 0, 13'h0003, 8'hC3, 8'h00, 8'h00, 8'h00, 0, 1, 8'h99, 0};

      reset = 1'b1; opreq = 1'b0; adr = '0; rw = 1'b0; m_io = 1'b0; d_c = 1'b0;
      cpu_dout = '0; mem_rdata = '0; port_ctl_in = '0; port_dat_in = '0;
      exp_din = '0; exp_pctl = '0; exp_pdat = '0;
      repeat (2) @(negedge clk);
      chk("reset_strobes", {opack2, ce2, oe2, we2, opack0, ce0, oe0, we0}, 8'b0111_0111);
      chk("reset_mem_adr", {mem_adr2, mem_adr0}, 26'd0);
      chk("reset_wdata", {mem_wdata2, mem_wdata0}, 16'd0);
      chk_state("reset");
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i].mio, vecs[i].wr, vecs[i].dc, vecs[i].a, vecs[i].wd, vecs[i].rd,
                 vecs[i].ci, vecs[i].di, vecs[i].hold, vecs[i].pulse, wc);
         chk("vec_din", 32'(cpu_din2), 32'(vecs[i].exp_din));
         chk("vec_we", wc, vecs[i].exp_we2);
      end

      // Reset lands in the middle of a memory write.
      @(negedge clk);
      m_io = 1'b1; rw = 1'b1; adr = 13'h1000; cpu_dout = 8'hE7; opreq = 1'b1;
      @(negedge clk);
      chk("pre_reset_we", we2, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("rst_strobes", {opack2, ce2, oe2, we2, opack0}, 5'b01110);
      chk("rst_mem_adr", mem_adr2, 13'd0);
      opreq = 1'b0;
      exp_din = '0; exp_pctl = '0; exp_pdat = '0;
      chk_state("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", {opack2, ce2, opack0, ce0}, 4'b0101);
      run_txn(1, 1, 0, 13'h1234, 8'hB6, 8'h00, 8'h00, 8'h00, 0, 0, wc);
      run_txn(1, 0, 0, 13'h1234, 8'h00, 8'h6B, 8'h00, 8'h00, 1, 0, wc);

      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 13'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 3), ($urandom_range(0, 3) == 0), wc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/as2650_bus_ctrl.md
AS2650_BUS_CTRL -- requirements
Module: as2650_bus_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 2, giving the number of extra cycles the memory strobes are held (legal range 0..15).
REQ-002 The block SHALL have parameter PROTECT_TOP, default 13'h0000; memory writes to adr < PROTECT_TOP are suppressed.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 adr  in  13  CPU address.
REQ-007 rw  in  1  CPU direction: 1=write, 0=read.
REQ-008 opreq  in  1  CPU operation request.
REQ-009 m_io  in  1  1=memory, 0=I/O.
REQ-010 d_c  in  1  I/O select: 1=data port, 0=control port.
REQ-011 cpu_dout  in  8  write data from CPU.
REQ-012 cpu_din  out  8  read data to CPU.
REQ-013 opack  out  1  operation acknowledge to CPU.
REQ-014 mem_adr  out  13  registered memory address.
REQ-015 mem_wdata  out  8  registered memory write data.
REQ-016 mem_rdata  in  8  memory read data.
REQ-017 mem_ce_n / mem_oe_n / mem_we_n  out  1 each  active-low memory strobes.
REQ-018 port_ctl_out / port_dat_out  out  8 each  I/O output registers.
REQ-019 port_ctl_in / port_dat_in  in  8 each  I/O input pins.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS, ACK.
REQ-021 IDLE: on a rising edge with opreq=1, the block SHALL latch adr, rw, m_io, d_c and cpu_dout; memory requests go to ACCESS with wait counter = WAIT_STATES; I/O requests go to ACK.
REQ-022 ACCESS: mem_ce_n=0; for a read, mem_oe_n=0; for an unprotected write, mem_we_n=0; mem_adr/mem_wdata hold the latched values.
REQ-023 ACCESS: the counter SHALL decrement each cycle; at counter=0, the block SHALL capture mem_rdata into cpu_din (reads) and move to ACK on that edge.
REQ-024 Memory access latency: opack rises 2+WAIT_STATES edges after the edge that samples opreq.
REQ-025 I/O reads SHALL capture the selected port_*_in into cpu_din on the IDLE->ACK edge; I/O writes SHALL load the selected port_*_out on the same edge; latency is 1 edge.
REQ-026 ACK: opack=1 and all memory strobes high; the block SHALL stay in ACK while opreq=1 and return to IDLE on the first edge with opreq=0.
REQ-027 cpu_din SHALL hold its last captured value outside ACK.
REQ-028 opreq dropping during ACCESS SHALL NOT abort the access: the block completes it, then asserts opack for exactly one cycle.
REQ-029 A protected write (m_io=1, rw=1, adr < PROTECT_TOP) SHALL run full ACCESS timing with mem_we_n=1 and SHALL still be acknowledged.
REQ-030 opack SHALL be 0 in IDLE and ACCESS, and requests SHALL NOT be sampled outside IDLE.
REQ-031 With WAIT_STATES=0, ACCESS SHALL last exactly one cycle.

Reset
REQ-032 Asserting reset SHALL immediately force: state IDLE, opack=0, mem_ce_n=mem_oe_n=mem_we_n=1, mem_adr=0, mem_wdata=0, cpu_din=0, port_ctl_out=port_dat_out=0, counter=0.
REQ-033 Reset asserted during ACCESS SHALL abort the access with no further strobes; after release, the block samples opreq only from the next edge.

Verification
REQ-034 Memory read, WAIT_STATES=2: adr=13'h0123, rw=0, m_io=1, mem_rdata=8'hA5 -> ce_n/oe_n low for 3 cycles, opack high 4 edges after request, cpu_din=8'hA5.
REQ-035 Memory write: adr=13'h1000, cpu_dout=8'h3C -> mem_we_n low for 3 cycles with mem_adr=13'h1000, mem_wdata=8'h3C, then opack=1.
REQ-036 Protected write, PROTECT_TOP=13'h0800, adr=13'h07FF -> mem_we_n stays 1 and opack still asserts; adr=13'h0800 -> mem_we_n asserts.
REQ-037 I/O: write d_c=1 with 8'h5A -> port_dat_out=8'h5A after 1 edge with opack=1; read d_c=0 with port_ctl_in=8'h81 -> cpu_din=8'h81.
REQ-038 Handshake: hold opreq high 5 cycles in ACK -> opack stays 1 and no new access occurs; drop opreq during ACCESS -> one-cycle opack, then IDLE.
REQ-039 Reset during ACCESS of a write -> mem_we_n=1 and opack=0 immediately, ports=0; next request completes normally.
